// File: rtl/xgmii_fifo_gmii_tx.sv
// xgmii_fifo_gmii_tx
// GMII-side read stage of the XGMII-to-GMII transmit path. Pops 72-bit
// {txc, txd} words from the async FIFO and serialises them one byte per
// gmii_clk, lane 0 first. Start words become preamble (0xFB -> 0x55), a
// terminate character ends the frame, and a minimum inter-frame gap is
// enforced between frames. Underruns and truncated frames (a new start
// word found where continuation data was expected) end the frame with a
// frame_abort pulse.
// Optional: define XGMII_FIFO_GMII_TX_ER_EN to add the gmii_er output,
// flagging in-frame 0xFE control bytes and abort points.
module xgmii_fifo_gmii_tx #(
  parameter int unsigned IFG_BYTES = 12
) (
  input  logic        gmii_clk,
  input  logic        sys_rst_n,
  input  logic [71:0] fifo_dout,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic        gmii_en,
  output logic [7:0]  gmii_txd,
  output logic        frame_done,
  output logic        frame_abort
`ifdef XGMII_FIFO_GMII_TX_ER_EN
  ,
  output logic        gmii_er
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ARM,
    SEND,
    ABORT
  } state_t;

  localparam logic [7:0] IFG_LOAD = 8'(IFG_BYTES - 1);
  localparam logic [7:0] XC_START = 8'hFB;
  localparam logic [7:0] XC_TERM  = 8'hFD;
`ifdef XGMII_FIFO_GMII_TX_ER_EN
  localparam logic [7:0] XC_ERR   = 8'hFE;
`endif
  localparam logic [7:0] PREAMBLE = 8'h55;

  state_t      state, state_nx;
  logic [7:0]  ctl_reg, ctl_nx;
  logic [63:0] dat_reg, dat_nx;
  logic [2:0]  lane, lane_nx;
  logic        pf_ok, pf_ok_nx;
  logic        to_arm, to_arm_nx;
  logic [7:0]  ifg_cnt, ifg_nx;

  logic        rd_req;
  logic        en_nx;
  logic [7:0]  txd_nx;
  logic        done_nx;
  logic        abort_nx;
`ifdef XGMII_FIFO_GMII_TX_ER_EN
  logic        er_nx;
`endif

  logic [7:0]  cur_byte;
  logic        cur_ctrl;
  logic        cur_term;
  logic        dout_start;

  // Decode the lane being sent and classify the word on the FIFO read port
  always_comb begin
    cur_byte   = dat_reg[{lane, 3'b000} +: 8];
    cur_ctrl   = ctl_reg[lane];
    cur_term   = cur_ctrl && (cur_byte == XC_TERM);
    dout_start = fifo_dout[64] && (fifo_dout[7:0] == XC_START);
  end

  // Pop request is combinational so the word is valid in the following cycle;
  // held low while reset is asserted so every output is 0 during reset.
  assign fifo_rd_en = rd_req && sys_rst_n;

  // Next-state logic, lane sequencing and the GMII byte for the next cycle.
  // Lane 0 of a start word is emitted directly from CHECK/ARM (SEND then
  // resumes at lane 1) so preamble appears two cycles after the pop.
  always_comb begin
    state_nx  = state;
    ctl_nx    = ctl_reg;
    dat_nx    = dat_reg;
    lane_nx   = lane;
    pf_ok_nx  = pf_ok;
    to_arm_nx = to_arm;
    ifg_nx    = (!gmii_en && (ifg_cnt != '0)) ? ifg_cnt - 8'd1 : ifg_cnt;
    rd_req    = 1'b0;
    en_nx     = 1'b0;
    txd_nx    = '0;
    done_nx   = 1'b0;
    abort_nx  = 1'b0;
`ifdef XGMII_FIFO_GMII_TX_ER_EN
    er_nx     = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          rd_req   = 1'b1;
          state_nx = CHECK;
        end
      end
      CHECK: begin
        if (dout_start) begin
          {ctl_nx, dat_nx} = fifo_dout;
          if (ifg_cnt == '0) begin
            en_nx    = 1'b1;
            txd_nx   = PREAMBLE;
            lane_nx  = 3'd1;
            state_nx = SEND;
          end else begin
            state_nx = ARM;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      ARM: begin
        if (ifg_cnt == '0) begin
          en_nx    = 1'b1;
          txd_nx   = PREAMBLE;
          lane_nx  = 3'd1;
          state_nx = SEND;
        end
      end
      SEND: begin
        if (cur_term) begin
          done_nx = 1'b1;
          ifg_nx  = IFG_LOAD;
          // A terminate in lane 7 follows a prefetch; keep it if it starts a frame
          if ((lane == 3'd7) && pf_ok && dout_start) begin
            {ctl_nx, dat_nx} = fifo_dout;
            state_nx = ARM;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          en_nx   = 1'b1;
          txd_nx  = cur_byte;
`ifdef XGMII_FIFO_GMII_TX_ER_EN
          er_nx   = cur_ctrl && (cur_byte == XC_ERR);
`endif
          lane_nx = lane + 3'd1;
          if (lane == 3'd6) begin
            rd_req   = !fifo_empty;
            pf_ok_nx = !fifo_empty;
          end
          if (lane == 3'd7) begin
            if (pf_ok) begin
              {ctl_nx, dat_nx} = fifo_dout;
              if (dout_start) begin
                to_arm_nx = 1'b1;
                state_nx  = ABORT;
              end
            end else begin
              to_arm_nx = 1'b0;
              state_nx  = ABORT;
            end
          end
        end
      end
      ABORT: begin
        abort_nx = 1'b1;
        ifg_nx   = IFG_LOAD;
`ifdef XGMII_FIFO_GMII_TX_ER_EN
        en_nx    = 1'b1;
        er_nx    = 1'b1;
`endif
        state_nx = to_arm ? ARM : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Control state: FSM, held word, lane index, prefetch flag and gap counter
  always_ff @(posedge gmii_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      ctl_reg <= '0;
      dat_reg <= '0;
      lane    <= '0;
      pf_ok   <= 1'b0;
      to_arm  <= 1'b0;
      ifg_cnt <= '0;
    end else begin
      state   <= state_nx;
      ctl_reg <= ctl_nx;
      dat_reg <= dat_nx;
      lane    <= lane_nx;
      pf_ok   <= pf_ok_nx;
      to_arm  <= to_arm_nx;
      ifg_cnt <= ifg_nx;
    end
  end

  // Registered GMII outputs and frame status pulses
  always_ff @(posedge gmii_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      gmii_en     <= 1'b0;
      gmii_txd    <= '0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
`ifdef XGMII_FIFO_GMII_TX_ER_EN
      gmii_er     <= 1'b0;
`endif
    end else begin
      gmii_en     <= en_nx;
      gmii_txd    <= txd_nx;
      frame_done  <= done_nx;
      frame_abort <= abort_nx;
`ifdef XGMII_FIFO_GMII_TX_ER_EN
      gmii_er     <= er_nx;
`endif
    end
  end

endmodule

// File: tb/tb_xgmii_fifo_gmii_tx.sv
// Directed bench for xgmii_fifo_gmii_tx: two instances (IFG 12 and IFG 3)
// fed from identical word streams through simple FIFO models.
module tb_xgmii_fifo_gmii_tx;

  localparam logic [71:0] START_W = {8'h01, 64'hd5555555555555fb};
  localparam logic [71:0] IDLE_W  = {8'hff, 64'h0707070707070707};
`ifdef XGMII_FIFO_GMII_TX_ER_EN
  localparam int ER_EXTRA = 1;
`else
  localparam int ER_EXTRA = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [71:0] a_dout = '0, b_dout = '0;
  logic a_empty, b_empty, a_rd, b_rd, a_en, b_en;
  logic a_done, b_done, a_abort, b_abort;
  logic [7:0] a_txd, b_txd;
`ifdef XGMII_FIFO_GMII_TX_ER_EN
  logic a_er, b_er;
`endif

  xgmii_fifo_gmii_tx #(.IFG_BYTES(12)) u_dut_a (
    .gmii_clk(clk), .sys_rst_n(rst_n), .fifo_dout(a_dout), .fifo_empty(a_empty),
    .fifo_rd_en(a_rd), .gmii_en(a_en), .gmii_txd(a_txd), .frame_done(a_done),
    .frame_abort(a_abort)
`ifdef XGMII_FIFO_GMII_TX_ER_EN
    , .gmii_er(a_er)
`endif
  );

  xgmii_fifo_gmii_tx #(.IFG_BYTES(3)) u_dut_b (
    .gmii_clk(clk), .sys_rst_n(rst_n), .fifo_dout(b_dout), .fifo_empty(b_empty),
    .fifo_rd_en(b_rd), .gmii_en(b_en), .gmii_txd(b_txd), .frame_done(b_done),
    .frame_abort(b_abort)
`ifdef XGMII_FIFO_GMII_TX_ER_EN
    , .gmii_er(b_er)
`endif
  );

  // FIFO models
  logic [71:0] qa[$], qb[$];
  int a_push = 0, b_push = 0, a_pops = 0, b_pops = 0;
  assign a_empty = (a_push == a_pops);
  assign b_empty = (b_push == b_pops);

  always @(posedge clk) begin
    if (a_rd && qa.size() != 0) begin
      a_dout <= qa.pop_front();
      a_pops <= a_pops + 1;
    end
    if (b_rd && qb.size() != 0) begin
      b_dout <= qb.pop_front();
      b_pops <= b_pops + 1;
    end
  end

  // Output monitors
  logic a_en_q = 1'b0, b_en_q = 1'b0;
  int a_low = 0, b_low = 0, a_hi = 0;
  int a_ndone = 0, a_nabort = 0, b_ndone = 0;
  int a_viol = 0, b_viol = 0, a_both = 0;
  logic [7:0] a_bytes[$];
  int a_lens[$], a_gaps[$], b_gaps[$];
`ifdef XGMII_FIFO_GMII_TX_ER_EN
  logic a_ers[$];
`endif

  always @(negedge clk) begin
    if (a_en && !a_en_q) begin
      a_gaps.push_back(a_low);
      a_bytes.delete();
`ifdef XGMII_FIFO_GMII_TX_ER_EN
      a_ers.delete();
`endif
    end
    if (!a_en && a_en_q) a_lens.push_back(a_bytes.size());
    if (a_en) begin
      a_bytes.push_back(a_txd);
`ifdef XGMII_FIFO_GMII_TX_ER_EN
      a_ers.push_back(a_er);
`endif
      a_low <= 0;
      a_hi  <= a_hi + 1;
    end else begin
      a_low <= a_low + 1;
    end
    if (a_done) a_ndone <= a_ndone + 1;
    if (a_abort) a_nabort <= a_nabort + 1;
    if (a_done && a_abort) a_both <= a_both + 1;
    if (a_rd && a_empty) a_viol <= a_viol + 1;
    a_en_q <= a_en;
  end

  always @(negedge clk) begin
    if (b_en && !b_en_q) b_gaps.push_back(b_low);
    if (b_en) b_low <= 0;
    else b_low <= b_low + 1;
    if (b_done) b_ndone <= b_ndone + 1;
    if (b_rd && b_empty) b_viol <= b_viol + 1;
    b_en_q <= b_en;
  end

  // Checking
  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stimulus helpers
  logic [7:0] exp_q[$];
  int l0, g0, gb0, d0, ab0, p0, h0, db0;

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    l0 = a_lens.size(); g0 = a_gaps.size(); gb0 = b_gaps.size();
    d0 = a_ndone; ab0 = a_nabort; p0 = a_pops; h0 = a_hi; db0 = b_ndone;
  endtask

  task automatic push_word(input logic [71:0] x);
    qa.push_back(x);
    qb.push_back(x);
    a_push++;
    b_push++;
  endtask

  // Start word, nw full data words, then a word terminating in lane tl
  task automatic push_frame(input int nw, input int tl, input logic [7:0] seed);
    logic [63:0] d;
    logic [7:0] c, v;
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    push_word(START_W);
    v = seed;
    for (int k = 0; k < nw; k++) begin
      for (int i = 0; i < 8; i++) begin
        d[i*8 +: 8] = v;
        exp_q.push_back(v);
        v++;
      end
      push_word({8'h00, d});
    end
    c = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < tl) begin
        d[i*8 +: 8] = v;
        exp_q.push_back(v);
        v++;
      end else begin
        c[i] = 1'b1;
        d[i*8 +: 8] = (i == tl) ? 8'hFD : 8'h07;
      end
    end
    push_word({c, d});
  endtask

  function automatic int payload_errs();
    int e = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= a_bytes.size() || a_bytes[i] !== exp_q[i]) e++;
    return e;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int found;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    // 64-byte class frame pre-filled during reset: 7 data words + 3 bytes
    push_frame(7, 3, 8'h01);
    snap();
    run(3);
    check("rst_en", a_en, 0);
    check("rst_txd", a_txd, 0);
    check("rst_rd_en", a_rd, 0);
    check("rst_done", a_done, 0);
    check("rst_abort", a_abort, 0);

    // Latency: pop in cycle T, preamble visible in T+2
    rst_n = 1'b1;
    #1;
    found = 0;
    for (int i = 0; i < 8 && found == 0; i++) begin
      if (a_rd) found = 1;
      else @(negedge clk);
    end
    check("first_pop_seen", found, 1);
    @(negedge clk);
    check("lat_t1_en", a_en, 0);
    @(negedge clk);
    check("lat_t2_en", a_en, 1);
    check("lat_t2_txd", a_txd, 8'h55);
    run(100);
    check("f1_len", a_lens[l0], 67);
    check("f1_sfd", a_bytes[7], 8'hD5);
    check("f1_payload_errs", payload_errs(), 0);
    check("f1_done_pulses", a_ndone - d0, 1);
    check("f1_abort_pulses", a_nabort - ab0, 0);

    // Idle words only: popped and discarded, no transmission
    snap();
    for (int i = 0; i < 3; i++) push_word(IDLE_W);
    run(20);
    check("idle_pops", a_pops - p0, 3);
    check("idle_en_cycles", a_hi - h0, 0);
    check("idle_done", a_ndone - d0, 0);

    // Back-to-back frames with an idle word between
    snap();
    push_frame(2, 3, 8'h10);
    push_word(IDLE_W);
    push_frame(3, 6, 8'h20);
    run(150);
    check("b2b_idle_len1", a_lens[l0], 27);
    check("b2b_idle_len2", a_lens[l0+1], 38);
    check("b2b_idle_gap_ifg12", a_gaps[g0+1], 12);
    check("b2b_idle_payload2", payload_errs(), 0);
    check("b2b_idle_done", a_ndone - d0, 2);

    // Back-to-back frames, no idle word: exact gap for both IFG settings
    snap();
    push_frame(1, 2, 8'h30);
    push_frame(1, 5, 8'h38);
    run(120);
    check("b2b_gap_ifg12", a_gaps[g0+1], 12);
    check("b2b_gap_ifg3", b_gaps[gb0+1], 3);
    check("b2b_done_ifg3", b_ndone - db0, 2);

    // Underrun: frame with no terminate, FIFO runs dry at lane 6
    snap();
    push_word(START_W);
    push_word({8'h00, 64'h0807060504030201});
    push_word({8'h00, 64'h100f0e0d0c0b0a09});
    run(60);
    check("ur_len", a_lens[l0], 24 + ER_EXTRA);
    check("ur_abort", a_nabort - ab0, 1);
    check("ur_done", a_ndone - d0, 0);
    check("ur_pops", a_pops - p0, 3);
    check("ur_rd_idle", a_rd, 0);
    // Residue word then a good frame
    snap();
    push_word({8'h00, 64'h1817161514131211});
    push_frame(1, 4, 8'h80);
    run(60);
    check("ur_recover_len", a_lens[l0], 20);
    check("ur_recover_payload", payload_errs(), 0);
    check("ur_recover_done", a_ndone - d0, 1);

    // Truncated frame: start word followed directly by another start word
    snap();
    push_word(START_W);
    push_frame(1, 3, 8'h90);
    run(80);
    check("tr_len1", a_lens[l0], 8 + ER_EXTRA);
    check("tr_len2", a_lens[l0+1], 19);
    check("tr_abort", a_nabort - ab0, 1);
    check("tr_done", a_ndone - d0, 1);
    check("tr_gap_ifg12", a_gaps[g0+1], 12);
    check("tr_gap_ifg3", b_gaps[gb0+1], 3);
    check("tr_payload2", payload_errs(), 0);

    // In-frame 0xFE control byte passes through in lane 2 of the data word
    snap();
    push_word(START_W);
    push_word({8'h04, 64'h1716151413fe1110});
    push_word({8'hff, 64'h07070707070707fd});
    run(60);
    check("fe_len", a_lens[l0], 16);
    check("fe_byte", a_bytes[10], 8'hFE);
    check("fe_prev_byte", a_bytes[9], 8'h11);
`ifdef XGMII_FIFO_GMII_TX_ER_EN
    check("fe_er", a_ers[10], 1);
    check("fe_er_prev", a_ers[9], 0);
`endif

    // Reset pulsed mid-frame
    push_frame(6, 2, 8'h50);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (a_en) found = 1;
    end
    run(10);
    check("mid_in_frame", a_en, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_en", a_en, 0);
    check("mid_rst_txd", a_txd, 0);
    check("mid_rst_rd", a_rd, 0);
    check("mid_rst_en_b", b_en, 0);
    run(3);
    rst_n = 1'b1;
    run(2);
    snap();
    push_frame(2, 5, 8'h40);
    run(150);
    check("post_rst_len", a_lens[l0], 29);
    check("post_rst_payload", payload_errs(), 0);
    check("post_rst_done", a_ndone - d0, 1);

    check("rd_on_empty_a", a_viol, 0);
    check("rd_on_empty_b", b_viol, 0);
    check("done_and_abort", a_both, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
